// File: rtl/gru_cell_seq.sv
// Sequential single-unit GRU cell; one shared multiplier stepped by an FSM, h carried between steps.
// Latency: accept at edge k -> out_valid after edge k+8. in_ready only in IDLE; OUT holds until out_ready.
module gru_cell_seq #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int W_Z    = 0,
    parameter int U_Z    = 0,
    parameter int B_Z    = 0,
    parameter int W_R    = 0,
    parameter int U_R    = 0,
    parameter int B_R    = 32,
    parameter int W_H    = 16,
    parameter int U_H    = 0,
    parameter int B_H    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [DATA_W-1:0] h_init,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_h,
    output logic              out_last
);

    localparam int MUL_W = DATA_W + 1;
    localparam int ACC_W = 2 * DATA_W + 2;

    localparam logic signed [DATA_W-1:0] W_Z_C = DATA_W'(W_Z);
    localparam logic signed [DATA_W-1:0] U_Z_C = DATA_W'(U_Z);
    localparam logic signed [DATA_W-1:0] W_R_C = DATA_W'(W_R);
    localparam logic signed [DATA_W-1:0] U_R_C = DATA_W'(U_R);
    localparam logic signed [DATA_W-1:0] W_H_C = DATA_W'(W_H);
    localparam logic signed [DATA_W-1:0] U_H_C = DATA_W'(U_H);
    localparam logic signed [ACC_W-1:0]  B_Z_A = ACC_W'(B_Z);
    localparam logic signed [ACC_W-1:0]  B_R_A = ACC_W'(B_R);
    localparam logic signed [ACC_W-1:0]  B_H_A = ACC_W'(B_H);

    localparam logic signed [ACC_W-1:0] ONE_A  = ACC_W'(2 ** FRAC_W);
    localparam logic signed [ACC_W-1:0] NONE_A = ACC_W'(-(2 ** FRAC_W));
    localparam logic signed [ACC_W-1:0] HALF_A = ACC_W'(2 ** (FRAC_W - 1));
    localparam logic signed [ACC_W-1:0] MAX_A  = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIN_A  = ACC_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [3:0] {
        S_IDLE, S_Z0, S_Z1, S_R0, S_R1, S_RH, S_H0, S_H1, S_UPD, S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic                      last_q, last_d;
    logic signed [DATA_W-1:0]  h_q, h_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  z_q, z_d;
    logic signed [DATA_W-1:0]  r_q, r_d;
    logic signed [DATA_W-1:0]  rh_q, rh_d;
    logic signed [DATA_W-1:0]  hc_q, hc_d;
    logic [DATA_W-1:0]         out_h_q, out_h_d;
    logic                      out_last_q, out_last_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [MUL_W-1:0]   mul_a, mul_b;
    logic signed [ACC_W-1:0]   mul_p, mul_s;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [MUL_W-1:0]   diff;
    logic signed [ACC_W-1:0]   h_sum;
    logic signed [DATA_W-1:0]  h_new;

    function automatic logic signed [DATA_W-1:0] f_sig(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = (a >>> 2) + HALF_A;
        if (t[ACC_W-1]) begin
            t = '0;
        end else if (t > ONE_A) begin
            t = ONE_A;
        end
        return t[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] f_tanh(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = a;
        if (t > ONE_A) begin
            t = ONE_A;
        end else if (t < NONE_A) begin
            t = NONE_A;
        end
        return t[DATA_W-1:0];
    endfunction

    // Operand select for the single shared multiplier; one product per state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        diff  = MUL_W'(hc_q) - MUL_W'(h_q);
        unique case (state_q)
            S_Z0:  begin mul_a = MUL_W'(x_q);  mul_b = MUL_W'(W_Z_C); end
            S_Z1:  begin mul_a = MUL_W'(h_q);  mul_b = MUL_W'(U_Z_C); end
            S_R0:  begin mul_a = MUL_W'(x_q);  mul_b = MUL_W'(W_R_C); end
            S_R1:  begin mul_a = MUL_W'(h_q);  mul_b = MUL_W'(U_R_C); end
            S_RH:  begin mul_a = MUL_W'(r_q);  mul_b = MUL_W'(h_q);   end
            S_H0:  begin mul_a = MUL_W'(x_q);  mul_b = MUL_W'(W_H_C); end
            S_H1:  begin mul_a = MUL_W'(rh_q); mul_b = MUL_W'(U_H_C); end
            S_UPD: begin mul_a = MUL_W'(z_q);  mul_b = diff;          end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
    end

    assign mul_p   = mul_a * mul_b;
    assign mul_s   = mul_p >>> FRAC_W;
    assign acc_sum = acc_q + mul_s;

    always_comb begin
        h_sum = ACC_W'(h_q) + mul_s;
        if (h_sum > MAX_A) begin
            h_sum = MAX_A;
        end else if (h_sum < MIN_A) begin
            h_sum = MIN_A;
        end
        h_new = h_sum[DATA_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        last_d      = last_q;
        h_d         = h_q;
        acc_d       = acc_q;
        z_d         = z_q;
        r_d         = r_q;
        rh_d        = rh_q;
        hc_d        = hc_q;
        out_h_d     = out_h_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    last_d  = in_last;
                    state_d = S_Z0;
                    if (in_first) begin
                        h_d = h_init;
                    end
                end
            end
            S_Z0: begin
                acc_d   = mul_s + B_Z_A;
                state_d = S_Z1;
            end
            S_Z1: begin
                z_d     = f_sig(acc_sum);
                state_d = S_R0;
            end
            S_R0: begin
                acc_d   = mul_s + B_R_A;
                state_d = S_R1;
            end
            S_R1: begin
                r_d     = f_sig(acc_sum);
                state_d = S_RH;
            end
            S_RH: begin
                // r is within [0,1.0], so r*h never exceeds |h|.
                rh_d    = mul_s[DATA_W-1:0];
                state_d = S_H0;
            end
            S_H0: begin
                acc_d   = mul_s + B_H_A;
                state_d = S_H1;
            end
            S_H1: begin
                hc_d    = f_tanh(acc_sum);
                state_d = S_UPD;
            end
            S_UPD: begin
                h_d         = h_new;
                out_h_d     = h_new;
                out_last_d  = last_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            last_q      <= 1'b0;
            h_q         <= '0;
            acc_q       <= '0;
            z_q         <= '0;
            r_q         <= '0;
            rh_q        <= '0;
            hc_q        <= '0;
            out_h_q     <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            last_q      <= last_d;
            h_q         <= h_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            r_q         <= r_d;
            rh_q        <= rh_d;
            hc_q        <= hc_d;
            out_h_q     <= out_h_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_h     = out_h_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/gru_cell_seq.md
# gru_cell_seq

Sequential, parametrised single-unit GRU cell that processes a stream of inputs x[t] and carries its hidden state h internally between steps. It is the clocked successor to the combinational 8-bit gru_lstm datapath, with configurable width and fixed-point format, plus valid/ready handshakes and sequence start/end tagging. One shared multiplier is time-multiplexed by an FSM. It sits between an input sample source and downstream logic that consumes h[t].

## Interface
- DATA_W, 8: signed word width of x, h and weights.
- FRAC_W, 4: fractional bits (Q(DATA_W-FRAC_W).FRAC_W); DATA_W-FRAC_W >= 2 so 1.0 = 2^FRAC_W is representable.
- W_Z, U_Z, B_Z, 0, 0, 0: update-gate input weight, recurrent weight, bias (signed DATA_W).
- W_R, U_R, B_R, 0, 0, 32: reset-gate weights, bias (32 = 2.0 at defaults).
- W_H, U_H, B_H, 16, 0, 0: candidate weights, bias (16 = 1.0 at defaults).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x/in_first/in_last valid.
- in_ready  out  1  cell can accept a sample.
- in_x  in  DATA_W  signed input sample.
- in_first  in  1  first step of a sequence: h is loaded from h_init before computing.
- in_last  in  1  tag, returned on out_last.
- h_init  in  DATA_W  initial hidden state, sampled only on an accepted in_first beat.
- out_valid  out  1  out_h valid.
- out_ready  in  1  downstream accepts out_h.
- out_h  out  DATA_W  new hidden state h[t].
- out_last  out  1  in_last of the step that produced out_h.

## Operation
- z = sig(W_Z·x + U_Z·h + B_Z); r = sig(W_R·x + U_R·h + B_R); rh = r·h; hc = tanh(W_H·x + U_H·rh + B_H); h_new = h + z·(hc − h).
- Every product: full 2·DATA_W signed, then arithmetic shift right FRAC_W (floor). Biases added unshifted. Accumulator 2·DATA_W+2 bits, no intermediate saturation.
- sig(a) = clamp((a >>> 2) + 2^(FRAC_W−1), 0, 2^FRAC_W). tanh(a) = clamp(a, −2^FRAC_W, 2^FRAC_W). Activations operate on the full accumulator.
- rh uses r in [0,1.0], fits DATA_W. hc − h computed in DATA_W+1 bits. h_new saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- FSM states: IDLE, Z0 (W_Z·x), Z1 (+U_Z·h, z), R0, R1 (r), RH (r·h), H0, H1 (hc), UPD (h_new), OUT. One multiply per state; states advance unconditionally from Z0 through UPD.
- IDLE: in_ready=1. On in_valid&&in_ready: latch x, in_last; if in_first, h := h_init; go Z0.
- UPD→OUT edge writes h := h_new, out_h := h_new, out_valid := 1.
- OUT: hold out_h/out_last stable until out_valid&&out_ready, then IDLE. in_ready=0 outside IDLE (no overlap of steps).
- h persists across steps and across in_last; only in_first or reset changes it other than UPD.

## Timing
- Reset (async assert, sync-to-clk deassert by system): state=IDLE, h=0, out_h=0, out_valid=0, out_last=0, in_ready=1. No transfer is accepted while rst_n=0.
- Reset mid-step (any state Z0..OUT): step discarded, h=0, no out_valid.
- Latency: acceptance at edge k → out_valid high after edge k+8. Earliest next acceptance: edge after out handshake; out_valid&&out_ready at edge m → in_ready high after edge m. Throughput with out_ready tied 1: one step per 10 cycles.
- in_ready depends only on state (no combinational path from in_valid or out_ready).
- in_first with in_valid low has no effect; h_init ignored unless in_first beat accepted.

## Test plan
- Defaults (z=0.5, r=1.0, hc=clamp(x)), in_first=1 h_init=0, x=8 -> out_h=4 after edge k+8; next step x=8 in_first=0 -> out_h=6.
- x=127 with h_init=0 -> hc saturates to 16, out_h=8; x=−1 with h_init=0 -> z·(hc−h)=−8>>>4, out_h=−1 (0xFF, floor).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_h/out_last stable, in_ready=0, in_valid held with x=3 not accepted until 1 cycle after handshake.
- in_first reload: after h=6, accept in_first=1 h_init=−16 x=0 -> hc=0, out_h=−8; in_last=1 on that beat -> out_last=1.
- Override U_H=16, B_R=0 (r=0.5), h_init=16, x=0 -> rh=8, hc=8, out_h=12.
- Assert rst_n=0 during state H0 -> out_valid stays 0, out_h=0, in_ready=1 after release; next step x=8 in_first=0 -> out_h=4 (h restarted at 0).
